demux_nch: RTL and testbench

- Parametrised successor to the 2-channel 80 MHz deserializer demux.
- Splits an interleaved NCH*BPC-bit input word into NCH lanes of BPC bits each, with per-lane polarity inversion.
- Adds an enable state machine with a settling window, a qualified valid output, optional lane-order reversal, and per-lane idle detection.
- Sits between the fast sampling front end and the per-channel decoders in the deser400 path.

---
 rtl/demux_nch.sv | 170 +++++++++++++++++
 tb/tb_demux_nch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/demux_nch.sv
// demux_nch: splits an interleaved NCH*BPC-bit sample word into NCH lanes of
// BPC bits with per-lane polarity inversion, optional lane-order reversal,
// an enable/settling state machine, a qualified valid and per-lane idle flags.
// Optional per-lane activity statistics are built when DEMUX_STAT_EN is defined.
module demux_nch #(
    parameter int unsigned     NCH      = 2,
    parameter int unsigned     BPC      = 2,
    parameter logic [NCH-1:0]  INV_MASK = 2'b10,
    parameter int unsigned     WARM_CYC = 4,
    parameter int unsigned     IDLE_LEN = 8
) (
    input  logic               clk80,
    input  logic               reset,
    input  logic               enable,
    input  logic               rev,
    input  logic [NCH*BPC-1:0] din,
`ifdef DEMUX_STAT_EN
    input  logic               clr_stat,
    output logic [NCH*16-1:0]  stat_cnt,
`endif
    output logic [NCH*BPC-1:0] dout,
    output logic               valid,
    output logic [NCH-1:0]     idle
);

    localparam logic [7:0] WARM_LD = 8'(WARM_CYC);
    localparam logic [7:0] IDLE_LD = 8'(IDLE_LEN);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [7:0]         warm_cnt;
    logic [7:0]         warm_nxt;
    logic               rev_q;
    logic               rev_eff;
    logic [NCH*BPC-1:0] mapped;
    logic [NCH*BPC-1:0] word;
    logic [NCH-1:0]     lane_ones;
    logic [7:0]         idle_cnt [NCH];
    logic [7:0]         idle_inc [NCH];

    // De-interleave the input word into lanes and apply per-lane inversion
    always_comb begin
        mapped = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            for (int unsigned k = 0; k < BPC; k++) begin
                mapped[c*BPC + k] = din[k*NCH + (NCH - 1 - c)] ^ INV_MASK[c];
            end
        end
    end

    // On the OFF->WARM edge rev is being latched, so use it directly there
    assign rev_eff = (state == ST_OFF) ? rev : rev_q;

    // Apply lane-order reversal; inversion already travels with the source lane
    always_comb begin
        word = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (rev_eff) begin
                word[c*BPC +: BPC] = mapped[(NCH - 1 - c)*BPC +: BPC];
            end else begin
                word[c*BPC +: BPC] = mapped[c*BPC +: BPC];
            end
        end
    end

    // Per-lane all-ones flag and saturating idle-count increment
    always_comb begin
        lane_ones = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            lane_ones[c] = &word[c*BPC +: BPC];
            idle_inc[c]  = (idle_cnt[c] == 8'hFF) ? 8'hFF : idle_cnt[c] + 8'd1;
        end
    end

    // Next-state logic for the enable / settling sequence
    always_comb begin
        next_state = state;
        warm_nxt   = warm_cnt;
        case (state)
            ST_OFF: begin
                if (enable) begin
                    next_state = ST_WARM;
                    warm_nxt   = WARM_LD;
                end
            end
            ST_WARM: begin
                if (!enable) begin
                    next_state = ST_OFF;
                end else if (warm_cnt <= 8'd1) begin
                    next_state = ST_RUN;
                end else begin
                    warm_nxt = warm_cnt - 8'd1;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    next_state = ST_OFF;
                end
            end
            default: next_state = ST_OFF;
        endcase
    end

    // State, output register and lane-order latch; outputs follow the next
    // state so a dropped enable blanks dout on the same edge
    always_ff @(posedge clk80) begin
        if (reset) begin
            state    <= ST_OFF;
            warm_cnt <= '0;
            rev_q    <= 1'b0;
            dout     <= '1;
            valid    <= 1'b0;
        end else begin
            state    <= next_state;
            warm_cnt <= warm_nxt;
            if (state == ST_OFF && enable) begin
                rev_q <= rev;
            end
            dout  <= (next_state == ST_OFF) ? '1 : word;
            valid <= (next_state == ST_RUN);
        end
    end

    // Per-lane idle detection on the delivered word; held flagged while off
    always_ff @(posedge clk80) begin
        if (reset) begin
            idle <= '1;
            for (int unsigned c = 0; c < NCH; c++) begin
                idle_cnt[c] <= '0;
            end
        end else if (next_state == ST_OFF) begin
            idle <= '1;
            for (int unsigned c = 0; c < NCH; c++) begin
                idle_cnt[c] <= IDLE_LD;
            end
        end else begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (lane_ones[c]) begin
                    idle_cnt[c] <= idle_inc[c];
                    idle[c]     <= (idle_inc[c] >= IDLE_LD);
                end else begin
                    idle_cnt[c] <= '0;
                    idle[c]     <= 1'b0;
                end
            end
        end
    end

`ifdef DEMUX_STAT_EN
    // Per-lane saturating count of delivered (valid) words that are not all ones
    always_ff @(posedge clk80) begin
        if (reset || clr_stat) begin
            stat_cnt <= '0;
        end else if (next_state == ST_RUN) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                if (!lane_ones[c] && stat_cnt[c*16 +: 16] != 16'hFFFF) begin
                    stat_cnt[c*16 +: 16] <= stat_cnt[c*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_nch.sv
// Directed self-checking bench for demux_nch with default parameters.
// Statistics checks are included when DEMUX_STAT_EN is defined.
module tb_demux_nch;

    logic       clk80 = 1'b0;
    logic       reset;
    logic       enable;
    logic       rev;
    logic [3:0] din;
    logic [3:0] dout;
    logic       valid;
    logic [1:0] idle;
`ifdef DEMUX_STAT_EN
    logic        clr_stat;
    logic [31:0] stat_cnt;
`endif

    int vectors    = 0;
    int miscompares = 0;

    demux_nch #(
        .NCH(2), .BPC(2), .INV_MASK(2'b10), .WARM_CYC(4), .IDLE_LEN(8)
    ) dut (
        .clk80   (clk80),
        .reset   (reset),
        .enable  (enable),
        .rev     (rev),
        .din     (din),
`ifdef DEMUX_STAT_EN
        .clr_stat(clr_stat),
        .stat_cnt(stat_cnt),
`endif
        .dout    (dout),
        .valid   (valid),
        .idle    (idle)
    );

    always #5 clk80 = ~clk80;

    task automatic step();
        @(posedge clk80);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; rev = 1'b0; din = 4'b1010;
`ifdef DEMUX_STAT_EN
        clr_stat = 1'b0;
`endif
        step();
        chk("rst_dout", 32'(dout), 32'hF);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_idle", 32'(idle), 32'h3);

        reset = 1'b0;
        step();
        chk("off_dout", 32'(dout), 32'hF);
        chk("off_valid", 32'(valid), 32'h0);

        // Enter WARM: 1010 maps to all ones on both lanes
        enable = 1'b1;
        step();
        chk("warm0_dout", 32'(dout), 32'hF);
        chk("warm0_valid", 32'(valid), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("warm_valid", 32'(valid), 32'h0);
        end
        step();
        chk("run_valid", 32'(valid), 32'h1);
        chk("run_dout_1010", 32'(dout), 32'hF);

        din = 4'b0101; step();
        chk("dout_0101", 32'(dout), 32'h0);
        chk("idle_clr", 32'(idle), 32'h0);

        // lane0={din3,din1}=00, lane1={~din2,~din0}=10
        din = 4'b0001; step();
        chk("dout_0001", 32'(dout), 32'h8);

        // lane0=10, lane1=10
        din = 4'b1001; step();
        chk("dout_1001", 32'(dout), 32'hA);

        // Idle: eight all-ones words on both lanes
        din = 4'b1010;
        for (int i = 1; i <= 7; i++) begin
            step();
            chk("idle_pre", 32'(idle), 32'h0);
        end
        step();
        chk("idle_8th", 32'(idle), 32'h3);
        // lane0={0,1}=01, lane1=11: only idle[0] clears
        din = 4'b0010; step();
        chk("idle_lane0_drop", 32'(idle), 32'h2);
        chk("dout_0010", 32'(dout), 32'hD);

        // rev toggled in RUN is ignored
        rev = 1'b1; din = 4'b0001; step();
        chk("rev_ignored", 32'(dout), 32'h8);
        chk("rev_ign_valid", 32'(valid), 32'h1);

        // Drop enable: blank on the same edge
        enable = 1'b0; din = 4'b0101; step();
        chk("drop_dout", 32'(dout), 32'hF);
        chk("drop_valid", 32'(valid), 32'h0);
        chk("drop_idle", 32'(idle), 32'h3);

        // Re-enable with rev=1: lanes swapped, lane0=10, lane1=00
        enable = 1'b1; din = 4'b0001; step();
        chk("rev_warm_dout", 32'(dout), 32'h2);
        chk("rev_warm_valid", 32'(valid), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("rewarm_valid", 32'(valid), 32'h0);
        end
        step();
        chk("rerun_valid", 32'(valid), 32'h1);
        chk("rerun_dout", 32'(dout), 32'h2);
        rev = 1'b0; step();
        chk("rev_latched", 32'(dout), 32'h2);

        // Reset dominates enable mid-RUN
        reset = 1'b1; step();
        chk("rst_run_dout", 32'(dout), 32'hF);
        chk("rst_run_valid", 32'(valid), 32'h0);
        chk("rst_run_idle", 32'(idle), 32'h3);
`ifdef DEMUX_STAT_EN
        chk("rst_stat", stat_cnt, 32'h0);
`endif

        // rev_q cleared: re-entry with rev=0 gives unswapped mapping
        reset = 1'b0; step();
        chk("post_rst_dout", 32'(dout), 32'h8);
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("post_rst_warm", 32'(valid), 32'h0);
        end
        step();
        chk("post_rst_valid", 32'(valid), 32'h1);

`ifdef DEMUX_STAT_EN
        // Entering edge counted once; nine more give ten on both lanes
        for (int i = 1; i <= 9; i++) step();
        chk("stat_10", stat_cnt, {16'd10, 16'd10});
        clr_stat = 1'b1; step();
        chk("stat_clr", stat_cnt, 32'h0);
        clr_stat = 1'b0;
        for (int i = 0; i < 70000; i++) step();
        chk("stat_sat", stat_cnt, {16'hFFFF, 16'hFFFF});
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
